// File: rtl/result_tx_pkg.sv
// Shared types, constants and helpers for the inference-result stream transmitter.
// Provides the FSM state encoding, the header magic word and a sign-extension helper.
// No logic or ports; imported by result_tx_hold and axis_result_tx.
package result_tx_pkg;

   // HDR is only reachable when RESULT_TX_HEADER_EN is defined.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HDR  = 2'd1,
      SEND = 2'd2
   } state_t;

   // Upper half of the optional header beat; the lower half carries frame_count.
   localparam logic [15:0] HDR_MAGIC = 16'hA55A;

   // Widest beat the sign-extension helper can produce.  Callers cast the
   // result down to their own TDATA_WIDTH.
   localparam int MAX_W = 64;

   // Replicate bit (i_width-1) of i_val into every bit above it.
   function automatic logic [MAX_W-1:0] sign_extend(input logic [MAX_W-1:0] i_val,
                                                    input int                i_width);
      logic [MAX_W-1:0] ext;
      ext = i_val;
      for (int i = 0; i < MAX_W; i++) begin
         if (i >= i_width) begin
            ext[i] = i_val[i_width-1];
         end
      end
      return ext;
   endfunction

endpackage

// File: rtl/result_tx_hold.sv
// Result hold register plus beat-select mux for the result stream transmitter.
// Latency: capture takes effect one cycle after i_load; the mux output is combinational.
// Backpressure: none here -- the hold contents only change when the FSM asserts i_load.
//
// Ports:
//   i_clk, i_rst_n  clock and asynchronous active-low reset
//   i_clr           synchronous clear (soft reset)
//   i_load          capture i_data / i_class into the hold registers
//   i_data, i_class neuron outputs (neuron 0 in the LSBs) and winning class index
//   i_sel           beat index: 0..NUM_OUT-1 selects a neuron, NUM_OUT selects the class
//   o_tdata         selected beat payload (neurons sign-extended, class zero-extended)
module result_tx_hold
   import result_tx_pkg::*;
#(
   parameter int DATA_WIDTH  = 16,
   parameter int NUM_OUT     = 10,
   parameter int TDATA_WIDTH = 32,
   parameter int CLASS_WIDTH = 32,
   parameter int CNT_W       = $clog2(NUM_OUT + 1)
) (
   input  logic                          i_clk,
   input  logic                          i_rst_n,
   input  logic                          i_clr,
   input  logic                          i_load,
   input  logic [NUM_OUT*DATA_WIDTH-1:0] i_data,
   input  logic [CLASS_WIDTH-1:0]        i_class,
   input  logic [CNT_W-1:0]              i_sel,
   output logic [TDATA_WIDTH-1:0]        o_tdata
);

   logic [NUM_OUT*DATA_WIDTH-1:0] r_data;
   logic [CLASS_WIDTH-1:0]        r_class;

   logic [DATA_WIDTH-1:0]         w_neuron;
   logic [MAX_W-1:0]              w_wide;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_data  <= '0;
         r_class <= '0;
      end else if (i_clr) begin
         r_data  <= '0;
         r_class <= '0;
      end else if (i_load) begin
         r_data  <= i_data;
         r_class <= i_class;
      end
   end

   // Constant-index unrolled mux keeps the part-select in range for every
   // i_sel value, including the class beat index NUM_OUT.
   always_comb begin
      w_neuron = '0;
      for (int k = 0; k < NUM_OUT; k++) begin
         if (i_sel == CNT_W'(k)) begin
            w_neuron = r_data[k*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   always_comb begin
      w_wide                   = '0;
      w_wide[DATA_WIDTH-1:0]   = w_neuron;
      o_tdata                  = '0;
      if (i_sel < CNT_W'(NUM_OUT)) begin
         o_tdata = TDATA_WIDTH'(sign_extend(w_wide, DATA_WIDTH));
      end else begin
         o_tdata[CLASS_WIDTH-1:0] = r_class;
      end
   end

endmodule

// File: rtl/axis_result_tx.sv
// AXI4-Stream master sending one inference result frame: NUM_OUT neuron beats then the class beat (tlast).
// Latency: first tvalid one cycle after res_valid; a last-beat handshake with res_valid starts the next frame with no gap.
// Backpressure: full tready backpressure, beats held stable while stalled; res_valid during a frame is dropped and sets overflow.
//
// Optional feature: define RESULT_TX_HEADER_EN to prefix every frame with a
// header beat {16'hA55A, frame_count} (requires TDATA_WIDTH >= 32).
//
// Ports:
//   s_axi_aclk, s_axi_aresetn  clock and asynchronous active-low reset
//   soft_reset                 synchronous clear, active high
//   res_valid, res_data,       one-cycle result strobe, neuron outputs (neuron 0 in
//   res_class                  the LSBs) and max-finder class index
//   m_axis_t*                  AXI4-Stream master (tdata/tvalid/tready/tlast)
//   busy                       a frame is held or being transmitted
//   overflow                   sticky: a result arrived while busy and was dropped
//   frame_count                completed frames, wraps at 0xFFFF
//   tx_done                    one-cycle pulse the cycle after a frame's last beat
module axis_result_tx
   import result_tx_pkg::*;
#(
   parameter int DATA_WIDTH  = 16,
   parameter int NUM_OUT     = 10,
   parameter int TDATA_WIDTH = 32,
   parameter int CLASS_WIDTH = 32
) (
   input  logic                          s_axi_aclk,
   input  logic                          s_axi_aresetn,
   input  logic                          soft_reset,
   input  logic                          res_valid,
   input  logic [NUM_OUT*DATA_WIDTH-1:0] res_data,
   input  logic [CLASS_WIDTH-1:0]        res_class,
   output logic [TDATA_WIDTH-1:0]        m_axis_tdata,
   output logic                          m_axis_tvalid,
   input  logic                          m_axis_tready,
   output logic                          m_axis_tlast,
   output logic                          busy,
   output logic                          overflow,
   output logic [15:0]                   frame_count,
   output logic                          tx_done
);

   localparam int               CNT_W    = $clog2(NUM_OUT + 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_OUT);

`ifdef RESULT_TX_HEADER_EN
   localparam state_t FIRST_STATE = HDR;
`else
   localparam state_t FIRST_STATE = SEND;
`endif

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [15:0]      r_frame_count;
   logic             r_overflow;
   logic             r_tx_done;

   state_t           w_state_nxt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic             w_load;
   logic             w_done_nxt;
   logic             w_ovf_set;
   logic             w_tvalid;
   logic             w_tlast;
   logic             w_xfer;
   logic             w_last_xfer;
   logic [TDATA_WIDTH-1:0] w_hold_tdata;
   logic [TDATA_WIDTH-1:0] w_tdata;

   // ---------------------------------------------------------------- hold + mux
   result_tx_hold #(
      .DATA_WIDTH  (DATA_WIDTH),
      .NUM_OUT     (NUM_OUT),
      .TDATA_WIDTH (TDATA_WIDTH),
      .CLASS_WIDTH (CLASS_WIDTH),
      .CNT_W       (CNT_W)
   ) u_hold (
      .i_clk   (s_axi_aclk),
      .i_rst_n (s_axi_aresetn),
      .i_clr   (soft_reset),
      .i_load  (w_load),
      .i_data  (res_data),
      .i_class (res_class),
      .i_sel   (r_cnt),
      .o_tdata (w_hold_tdata)
   );

   assign w_xfer      = w_tvalid && m_axis_tready;
   assign w_last_xfer = w_xfer && w_tlast;

   // ---------------------------------------------------------------- state register
   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) begin
         r_state <= IDLE;
      end else if (soft_reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // ---------------------------------------------------------------- next state
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_load      = 1'b0;
      w_done_nxt  = 1'b0;
      w_ovf_set   = 1'b0;
      case (r_state)
         IDLE: begin
            if (res_valid) begin
               w_load      = 1'b1;
               w_cnt_nxt   = '0;
               w_state_nxt = FIRST_STATE;
            end
         end
`ifdef RESULT_TX_HEADER_EN
         HDR: begin
            if (res_valid) begin
               w_ovf_set = 1'b1;
            end
            if (w_xfer) begin
               w_state_nxt = SEND;
            end
         end
`endif
         SEND: begin
            if (w_last_xfer) begin
               w_done_nxt = 1'b1;
               // A result arriving on the closing handshake is accepted and
               // starts the next frame straight away.
               if (res_valid) begin
                  w_load      = 1'b1;
                  w_cnt_nxt   = '0;
                  w_state_nxt = FIRST_STATE;
               end else begin
                  w_state_nxt = IDLE;
               end
            end else begin
               if (res_valid) begin
                  w_ovf_set = 1'b1;
               end
               if (w_xfer) begin
                  w_cnt_nxt = r_cnt + CNT_W'(1);
               end
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------- outputs
   always_comb begin
      w_tvalid = (r_state != IDLE);
      w_tlast  = (r_state == SEND) && (r_cnt == LAST_CNT);
      w_tdata  = w_hold_tdata;
`ifdef RESULT_TX_HEADER_EN
      if (r_state == HDR) begin
         w_tdata        = '0;
         w_tdata[31:0]  = {HDR_MAGIC, r_frame_count};
      end
`endif
   end

   // ---------------------------------------------------------------- counters / flags
   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) begin
         r_cnt         <= '0;
         r_frame_count <= '0;
         r_overflow    <= 1'b0;
         r_tx_done     <= 1'b0;
      end else if (soft_reset) begin
         r_cnt         <= '0;
         r_frame_count <= '0;
         r_overflow    <= 1'b0;
         r_tx_done     <= 1'b0;
      end else begin
         r_cnt     <= w_cnt_nxt;
         r_tx_done <= w_done_nxt;
         if (w_done_nxt) begin
            r_frame_count <= r_frame_count + 16'd1;
         end
         if (w_ovf_set) begin
            r_overflow <= 1'b1;
         end
      end
   end

   assign m_axis_tdata  = w_tdata;
   assign m_axis_tvalid = w_tvalid;
   assign m_axis_tlast  = w_tlast;
   assign busy          = (r_state != IDLE);
   assign overflow      = r_overflow;
   assign frame_count   = r_frame_count;
   assign tx_done       = r_tx_done;

endmodule
